// File: rtl/clint_timer_pkg.sv
// Shared CLINT register offsets, register-file bundle and reset value.
// Consumed by clint_timer and clint_prescaler (CLINT_PRESCALE_EN build).
package clint_timer_pkg;

  localparam logic [15:0] clint_msip      = 16'h0000;
  localparam logic [15:0] clint_mtimecmp  = 16'h4000;
  localparam logic [15:0] clint_mtimecmph = 16'h4004;
  localparam logic [15:0] clint_mtime     = 16'hBFF8;
  localparam logic [15:0] clint_mtimeh    = 16'hBFFC;

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } clint_state_e;

  typedef struct packed {
    logic        msip;
    logic [63:0] mtimecmp;
    logic [63:0] mtime;
    logic [15:0] prescale_cnt;
  } clint_reg_type;

  localparam clint_reg_type init_clint_reg = '{
    msip:         1'b0,
    mtimecmp:     64'hFFFF_FFFF_FFFF_FFFF,
    mtime:        64'h0,
    prescale_cnt: 16'h0
  };

  function automatic logic [31:0] wmerge(
    input logic [31:0] old_v,
    input logic [31:0] wdata,
    input logic [3:0]  wstrb
  );
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (wstrb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Next-state logic for the mtime prescale counter (0..PRESCALE-1).
// Used only when CLINT_PRESCALE_EN is defined; tick_o marks the wrap.
module clint_prescaler
  import clint_timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 10
) (
  input  logic [15:0] cnt_i,
  output logic [15:0] cnt_o,
  output logic        tick_o
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  assign tick_o = (cnt_i == LAST);
  assign cnt_o  = tick_o ? 16'h0 : cnt_i + 16'd1;

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: msip, mtimecmp and mtime on the data bus.
// Define CLINT_PRESCALE_EN to advance mtime once every PRESCALE clocks.
module clint_timer
  import clint_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned PRESCALE  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clint_valid,
  input  logic        clint_instr,
  input  logic [31:0] clint_addr,
  input  logic [31:0] clint_wdata,
  input  logic [3:0]  clint_wstrb,
  output logic [31:0] clint_rdata,
  output logic        clint_ready,
  output logic        msip,
  output logic        mtip,
  output logic [63:0] mtime
);

  clint_reg_type r_q, r_d;
  clint_state_e  state_q;
  logic          ready_q;
  logic [31:0]   rdata_q;
  logic          mtip_q;

  logic        sel;
  logic        acc;
  logic        wr;
  logic [15:0] off;
  logic [31:0] rdata_d;
  logic        tick;

`ifdef CLINT_PRESCALE_EN
  logic [15:0] cnt_nxt;

  clint_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .cnt_i  (r_q.prescale_cnt),
    .cnt_o  (cnt_nxt),
    .tick_o (tick)
  );
`else
  assign tick = 1'b1;
`endif

  assign sel = clint_valid &&
               (clint_addr[31:16] == BASE_ADDR[31:16]);
  assign acc = sel && (state_q == ST_IDLE);
  assign wr  = acc && !clint_instr && (clint_wstrb != 4'h0);
  assign off = clint_addr[15:0];

  always_comb begin
    rdata_d = 32'h0;
    case (off)
      clint_msip:      rdata_d = {31'h0, r_q.msip};
      clint_mtimecmp:  rdata_d = r_q.mtimecmp[31:0];
      clint_mtimecmph: rdata_d = r_q.mtimecmp[63:32];
      clint_mtime:     rdata_d = r_q.mtime[31:0];
      clint_mtimeh:    rdata_d = r_q.mtime[63:32];
      default:         rdata_d = 32'h0;
    endcase
  end

  always_comb begin
    r_d = r_q;
`ifdef CLINT_PRESCALE_EN
    r_d.prescale_cnt = cnt_nxt;
`endif
    if (tick) r_d.mtime = r_q.mtime + 64'd1;
    // A bus write to mtime overrides this cycle's tick entirely
    if (wr) begin
      case (off)
        clint_msip:
          if (clint_wstrb[0]) r_d.msip = clint_wdata[0];
        clint_mtimecmp:
          r_d.mtimecmp[31:0] =
            wmerge(r_q.mtimecmp[31:0], clint_wdata, clint_wstrb);
        clint_mtimecmph:
          r_d.mtimecmp[63:32] =
            wmerge(r_q.mtimecmp[63:32], clint_wdata, clint_wstrb);
        clint_mtime:
          r_d.mtime = {r_q.mtime[63:32],
            wmerge(r_q.mtime[31:0], clint_wdata, clint_wstrb)};
        clint_mtimeh:
          r_d.mtime = {
            wmerge(r_q.mtime[63:32], clint_wdata, clint_wstrb),
            r_q.mtime[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q     <= init_clint_reg;
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      rdata_q <= 32'h0;
      mtip_q  <= 1'b0;
    end else begin
      r_q    <= r_d;
      mtip_q <= (r_q.mtime >= r_q.mtimecmp);
      case (state_q)
        ST_IDLE: begin
          if (acc) begin
            state_q <= ST_RESP;
            ready_q <= 1'b1;
            rdata_q <= rdata_d;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          rdata_q <= 32'h0;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          rdata_q <= 32'h0;
        end
      endcase
    end
  end

  assign clint_ready = ready_q;
  assign clint_rdata = rdata_q;
  assign msip        = r_q.msip;
  assign mtip        = mtip_q;
  assign mtime       = r_q.mtime;

endmodule

// File: tb/tb_clint_timer.sv
// Randomised bench for clint_timer against an arithmetic timer model.
// Also builds with CLINT_PRESCALE_EN (PRESCALE fixed to 4 here).
module tb_clint_timer;

`ifdef CLINT_PRESCALE_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clint_valid = 1'b0;
  logic        clint_instr = 1'b0;
  logic [31:0] clint_addr  = 32'h0;
  logic [31:0] clint_wdata = 32'h0;
  logic [3:0]  clint_wstrb = 4'h0;
  logic [31:0] clint_rdata;
  logic        clint_ready;
  logic        msip;
  logic        mtip;
  logic [63:0] mtime;

  clint_timer #(
    .BASE_ADDR (32'h0200_0000),
    .PRESCALE  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clint_valid (clint_valid),
    .clint_instr (clint_instr),
    .clint_addr  (clint_addr),
    .clint_wdata (clint_wdata),
    .clint_wstrb (clint_wstrb),
    .clint_rdata (clint_rdata),
    .clint_ready (clint_ready),
    .msip        (msip),
    .mtip        (mtip),
    .mtime       (mtime)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Edges since reset release; mtime is a pure function of it
  longint cyc;
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  logic [63:0] m_base   = 64'h0;
  longint      m_wcyc   = 0;
  logic [63:0] m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
  logic        m_msip   = 1'b0;
  logic [31:0] exp_rd   = 32'h0;
  longint      resp_cyc = -1;
  logic [63:0] prev_mt  = 64'h0;
  logic [63:0] prev_cmp = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [63:0] mt(longint n);
    return m_base + 64'((n / P) - (m_wcyc / P));
  endfunction

  function automatic logic [31:0] bmerge(
    logic [31:0] o, logic [31:0] w, logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = s[b] ? w[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", {63'h0, clint_ready}, 64'h0);
      chk("rst_rdata", {32'h0, clint_rdata}, 64'h0);
      chk("rst_mtime", mtime, 64'h0);
      chk("rst_mtip", {63'h0, mtip}, 64'h0);
      chk("rst_msip", {63'h0, msip}, 64'h0);
      prev_mt  = 64'h0;
      prev_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      chk("mtime", mtime, mt(cyc));
      chk("msip", {63'h0, msip}, {63'h0, m_msip});
      chk("mtip", {63'h0, mtip}, {63'h0, prev_mt >= prev_cmp});
      chk("ready", {63'h0, clint_ready}, {63'h0, cyc == resp_cyc});
      if (cyc == resp_cyc)
        chk("rdata", {32'h0, clint_rdata}, {32'h0, exp_rd});
      prev_mt  = mt(cyc);
      prev_cmp = m_cmp;
    end
  end

  task automatic access(
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [3:0]  st,
    input  logic        ins,
    output logic [31:0] rd
  );
    logic [63:0] pre, v;
    longint      n;
    @(negedge clk); #1;
    clint_valid = 1'b1;
    clint_addr  = a;
    clint_wdata = wd;
    clint_wstrb = st;
    clint_instr = ins;
    if (a[31:16] != 16'h0200) begin
      @(posedge clk); #1;
      clint_valid = 1'b0;
      clint_wstrb = 4'h0;
      clint_instr = 1'b0;
      rd = 32'h0;
      return;
    end
    // Held through the response cycle, where valid must be ignored
    if (cyc == resp_cyc) begin
      @(negedge clk); #1;
    end
    n   = cyc;
    pre = mt(n);
    case (a[15:0])
      16'h0000: exp_rd = {31'h0, m_msip};
      16'h4000: exp_rd = m_cmp[31:0];
      16'h4004: exp_rd = m_cmp[63:32];
      16'hBFF8: exp_rd = pre[31:0];
      16'hBFFC: exp_rd = pre[63:32];
      default:  exp_rd = 32'h0;
    endcase
    if (st != 4'h0 && !ins) begin
      v = pre;
      case (a[15:0])
        16'h0000: if (st[0]) m_msip = wd[0];
        16'h4000: m_cmp[31:0]  = bmerge(m_cmp[31:0], wd, st);
        16'h4004: m_cmp[63:32] = bmerge(m_cmp[63:32], wd, st);
        16'hBFF8: begin
          v[31:0] = bmerge(pre[31:0], wd, st);
          m_base = v; m_wcyc = n + 1;
        end
        16'hBFFC: begin
          v[63:32] = bmerge(pre[63:32], wd, st);
          m_base = v; m_wcyc = n + 1;
        end
        default: ;
      endcase
    end
    resp_cyc = n + 1;
    @(posedge clk); #1;
    rd = clint_rdata;
    clint_valid = 1'b0;
    clint_wstrb = 4'h0;
    clint_instr = 1'b0;
  endtask

  task automatic model_reset();
    m_base   = 64'h0;
    m_wcyc   = 0;
    m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
    m_msip   = 1'b0;
    resp_cyc = -1;
  endtask

  localparam logic [31:0] B = 32'h0200_0000;

  initial begin
    logic [31:0] rd;
    logic [15:0] offs [8];
    logic [15:0] o;
    logic [31:0] wd;
    logic [3:0]  st;
    bit          seen;
    offs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8,
             16'hBFFC, 16'h0004, 16'h4008, 16'hBFF0};

    model_reset();
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

`ifdef CLINT_PRESCALE_EN
    repeat (40) @(negedge clk);
    chk("presc_40cyc", mtime, 64'd10);
`else
    repeat (20) @(negedge clk);
    access(B + 32'hBFF8, 32'h0, 4'h0, 1'b0, rd);
    chk("idle20_range", {63'h0, rd >= 32'd20 && rd <= 32'd22}, 64'h1);
`endif

    access(B, 32'h1, 4'hF, 1'b0, rd);
    chk("msip_set", {63'h0, msip}, 64'h1);
    access(B, 32'h0, 4'hF, 1'b0, rd);
    chk("msip_clr", {63'h0, msip}, 64'h0);

    access(B + 32'h4004, 32'h0, 4'hF, 1'b0, rd);
    access(B + 32'hBFF8, 32'h0, 4'hF, 1'b0, rd);
    access(B + 32'h4000, 32'd50, 4'hF, 1'b0, rd);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = mtip;
    end
    chk("mtip_rise", {63'h0, seen}, 64'h1);
    chk("mtip_lag", mtime, (P == 1) ? 64'd51 : 64'd50);
    access(B + 32'h4000, 32'hFFFF_FFFF, 4'hF, 1'b0, rd);
    repeat (2) @(negedge clk);
    chk("mtip_fall", {63'h0, mtip}, 64'h0);

    access(B + 32'h4000, 32'h0000_AB00, 4'b0010, 1'b0, rd);
    access(B + 32'h4000, 32'h0, 4'h0, 1'b0, rd);
    chk("byte_wr", {32'h0, rd}, 64'h0000_0000_FFFF_ABFF);
    access(B + 32'h4000, 32'h0, 4'hF, 1'b1, rd);
    chk("instr_rd", {32'h0, rd}, 64'h0000_0000_FFFF_ABFF);

    access(B + 32'hBFFC, 32'h0, 4'hF, 1'b0, rd);
    access(B + 32'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b0, rd);
    repeat (2) @(negedge clk);
`ifndef CLINT_PRESCALE_EN
    access(B + 32'hBFFC, 32'h0, 4'h0, 1'b0, rd);
    chk("carry_hi", {32'h0, rd}, 64'h1);
`endif

    access(B + 32'hBFFC, 32'h0, 4'hF, 1'b0, rd);
    access(B + 32'hBFF8, 32'h1234, 4'hF, 1'b0, rd);
    chk("tick_wr_wins", mtime, 64'h1234);

    access(B + 32'h0010, 32'hDEAD_BEEF, 4'hF, 1'b0, rd);
    chk("unmapped_rd", {32'h0, rd}, 64'h0);

    for (int i = 0; i < 250; i++) begin
      o  = offs[$urandom_range(0, 7)];
      wd = $urandom;
      st = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom);
      if ((o == 16'h4004 || o == 16'hBFFC) && $urandom_range(0, 1))
        wd = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0)
        access(32'h1000_0000 | {16'h0, o}, wd, st, 1'b0, rd);
      else
        access(B | {16'h0, o}, wd, st,
               $urandom_range(0, 9) == 0, rd);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk); #1;
    clint_valid = 1'b1;
    clint_addr  = B;
    clint_wdata = 32'h1;
    clint_wstrb = 4'hF;
    #2 rst = 1'b1;
    clint_valid = 1'b0;
    clint_wstrb = 4'h0;
    model_reset();
    @(posedge clk); #1;
    chk("abort_ready", {63'h0, clint_ready}, 64'h0);
    chk("abort_msip", {63'h0, msip}, 64'h0);
    chk("abort_mtime", mtime, 64'h0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    access(B + 32'h4004, 32'h0, 4'h0, 1'b0, rd);
    chk("post_rst_cmph", {32'h0, rd}, 64'hFFFF_FFFF);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
Core-local interruptor: memory-mapped timer and software-interrupt source that drives the core's mtip, msip and mtime inputs. It is the producing end of the machine-interrupt interface consumed by the CSR unit. It sits on the data-memory bus as a slave beside RAM and UART. Register layout follows the standard CLINT map: msip, mtimecmp and mtime.

Parameters:
BASE_ADDR, 32'h0200_0000, base address; bits [31:16] are decoded.
PRESCALE, 10, clk cycles per mtime increment; legal range 1..65535. Used only with CLINT_PRESCALE_EN.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
clint_valid  in  1  request strobe; held until clint_ready
clint_instr  in  1  instruction fetch flag; treated as a read
clint_addr  in  32  byte address
clint_wdata  in  32  write data
clint_wstrb  in  4  byte enables; 0 means read
clint_rdata  out  32  read data, valid while clint_ready=1
clint_ready  out  1  one-cycle completion pulse
msip  out  1  software interrupt pending
mtip  out  1  timer interrupt pending
mtime  out  64  current timer value

Behaviour:
- Reset (async, rst=1): mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip reg=0, prescale counter=0, state=IDLE, clint_ready=0, clint_rdata=0, mtip=0, msip=0.
- Register map at offset = clint_addr[15:0], selected when clint_addr[31:16]==BASE_ADDR[31:16]:
  - 0x0000 msip: bit0 is RW; bits [31:1] read 0.
  - 0x4000 mtimecmp[31:0]
  - 0x4004 mtimecmp[63:32]
  - 0xBFF8 mtime[31:0]
  - 0xBFFC mtime[63:32]
- Unmapped offsets: read 0, writes ignored, still acknowledged. There is no bus error.
- Handshake FSM:
  - IDLE: when clint_valid=1 and addr selected, perform the access this cycle and go to RESP. clint_ready=1 and clint_rdata are registered.
  - RESP: clint_ready=1 for exactly one cycle, then IDLE. clint_valid is ignored in RESP, so back-to-back requests cost 2 cycles each.
  - If clint_valid=1 but the address is not selected, stay IDLE with no response.
- Writes honour clint_wstrb per byte. Read data is the register value before any same-cycle write.
- 32-bit half writes do not carry between halves. Software must use the standard hi/lo/hi sequence.
- mtime tick:
  - Without the macro: mtime+1 every cycle.
  - With the macro: a 16-bit counter counts 0..PRESCALE-1. On wrap, mtime+1.
  - A bus write to either mtime half in the same cycle as a tick wins; no increment that cycle. The prescale counter keeps running.
  - mtime wraps 2^64-1 -> 0 silently.
- mtip registered: mtip <= (mtime >= mtimecmp), 64-bit unsigned compare on current register values, giving 1-cycle lag. It is level, not sticky, and clears by writing a larger mtimecmp.
- msip output = msip reg bit0, direct from the flop.
- mtime output = mtime register, direct from the flop.
- Reset asserted mid-transaction aborts it; no clint_ready is produced.

Optional Feature:
CLINT_PRESCALE_EN
- Defined: mtime advances once every PRESCALE clk cycles (prescale counter present).
- Undefined: counter and PRESCALE are unused; mtime advances every clk cycle.

Decomposition:
- Shared constants package:
  - offsets clint_msip=16'h0000, clint_mtimecmp=16'h4000, clint_mtimecmph=16'h4004, clint_mtime=16'hBFF8, clint_mtimeh=16'hBFFC
  - clint_reg_type struct (msip, mtimecmp, mtime, prescale count)
  - init_clint_reg constant
- Sub-module clint_prescaler (counter + tick pulse), instantiated only under the macro.
- Bus FSM, registers and compare stay in clint_timer.

Test Plan:
- Reset then idle 20 cycles (macro off) -> mtime=20±1 on read of 0xBFF8, mtip=0, msip=0.
- Write 1 to 0x0200_0000 -> clint_ready pulses 1 cycle later, msip=1. Write 0 -> msip=0.
- Write mtimecmp hi=0, lo=50 -> mtip rises exactly one cycle after mtime reaches 50. Write lo=0xFFFF_FFFF -> mtip falls.
- Write mtime lo=0xFFFF_FFFF, hi=0 -> next ticks read hi=1, lo=0 (carry within counter). Write on a tick cycle -> written value held, no +1.
- Byte write wstrb=4'b0010, wdata=32'h0000_AB00 to mtimecmp lo (was 0xFFFF_FFFF) -> reads 0xFFFF_ABFF.
- Macro on, PRESCALE=4: 40 cycles -> mtime=10. Assert rst mid-request -> no clint_ready, all registers at reset values.
